// File: rtl/regbank_xfer_if.sv
// rtl/regbank_xfer_if.sv - command and register-bank signal bundle for regbank_xfer
// master = host/bank side, slave = the transfer sequencer.
interface regbank_xfer_if;
   logic        start;
   logic [1:0]  op;
   logic [2:0]  src;
   logic [2:0]  dst;
   logic [15:0] imm;
   logic [15:0] bus;
   logic [15:0] in;
   logic [2:0]  rsel;
   logic        wrr;
   logic        tr;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] rdata;

   modport master (
      output start, op, src, dst, imm, bus,
      input  in, rsel, wrr, tr, busy, done, err, rdata
   );

   modport slave (
      input  start, op, src, dst, imm, bus,
      output in, rsel, wrr, tr, busy, done, err, rdata
   );
endinterface

// File: rtl/regbank_xfer.sv
// rtl/regbank_xfer.sv - register-bank MOV/SWAP/LOAD/READ sequencer, one bank phase per cycle
// Optional SWAP support is compiled in by defining REGBANK_XFER_SWAP_EN.
module regbank_xfer (
   input  logic           clk,
   input  logic           reset,
   regbank_xfer_if.slave  xif
);
   localparam logic [1:0] OP_MOV  = 2'b00;
   localparam logic [1:0] OP_SWAP = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

`ifdef REGBANK_XFER_SWAP_EN
   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, RD_A, WR_A, DONE} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  op_q;
   logic [2:0]  src_q;
   logic [2:0]  dst_q;
   logic [15:0] imm_q;
   logic        err_q;
   logic [15:0] tmp_a_q;
   logic [15:0] rdata_q;
   logic        op_illegal;
`ifdef REGBANK_XFER_SWAP_EN
   logic [15:0] tmp_b_q;
   assign op_illegal = 1'b0;
`else
   assign op_illegal = (xif.op == OP_SWAP);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         op_q    <= OP_MOV;
         src_q   <= 3'd0;
         dst_q   <= 3'd0;
         imm_q   <= 16'h0000;
         err_q   <= 1'b0;
         tmp_a_q <= 16'h0000;
         rdata_q <= 16'h0000;
`ifdef REGBANK_XFER_SWAP_EN
         tmp_b_q <= 16'h0000;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && xif.start) begin
            op_q  <= xif.op;
            src_q <= xif.src;
            dst_q <= xif.dst;
            imm_q <= xif.imm;
            err_q <= op_illegal;
         end
         // Bank data is only valid while tr=1, so capture on the edge closing the read phase.
         if (state_q == RD_A) begin
            tmp_a_q <= xif.bus;
            if (op_q == OP_READ) rdata_q <= xif.bus;
         end
`ifdef REGBANK_XFER_SWAP_EN
         if (state_q == RD_B) tmp_b_q <= xif.bus;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      xif.tr   = 1'b0;
      xif.wrr  = 1'b0;
      xif.rsel = 3'd0;
      xif.in   = 16'h0000;
      xif.done = 1'b0;
      xif.err  = 1'b0;
      case (state_q)
         IDLE: begin
            if (xif.start) begin
               if (op_illegal)             state_d = DONE;
               else if (xif.op == OP_LOAD) state_d = WR_A;
               else                        state_d = RD_A;
            end
         end
         RD_A: begin
            xif.tr   = 1'b1;
            xif.rsel = src_q;
            state_d  = (op_q == OP_READ) ? DONE : WR_A;
`ifdef REGBANK_XFER_SWAP_EN
            if (op_q == OP_SWAP) state_d = RD_B;
`endif
         end
`ifdef REGBANK_XFER_SWAP_EN
         RD_B: begin
            xif.tr   = 1'b1;
            xif.rsel = dst_q;
            state_d  = WR_A;
         end
`endif
         WR_A: begin
            xif.wrr  = 1'b1;
            xif.rsel = dst_q;
            xif.in   = (op_q == OP_LOAD) ? imm_q : tmp_a_q;
            state_d  = DONE;
`ifdef REGBANK_XFER_SWAP_EN
            if (op_q == OP_SWAP) begin
               xif.rsel = src_q;
               xif.in   = tmp_b_q;
               state_d  = WR_B;
            end
`endif
         end
`ifdef REGBANK_XFER_SWAP_EN
         WR_B: begin
            xif.wrr  = 1'b1;
            xif.rsel = dst_q;
            xif.in   = tmp_a_q;
            state_d  = DONE;
         end
`endif
         DONE: begin
            xif.done = 1'b1;
            xif.err  = err_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign xif.busy  = (state_q != IDLE);
   assign xif.rdata = rdata_q;
endmodule

// File: doc/regbank_xfer.md
REGBANK_XFER -- requirements
Module: regbank_xfer

Interface
REQ-001 SHALL provide ports: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL provide ports: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide ports: start  input  1  command request, sampled only in IDLE.
REQ-004 SHALL provide ports: op  input  2  00 MOV, 01 SWAP, 10 LOAD, 11 READ.
REQ-005 SHALL provide ports: src  input  3  source register index.
REQ-006 SHALL provide ports: dst  input  3  destination register index.
REQ-007 SHALL provide ports: imm  input  16  LOAD immediate.
REQ-008 SHALL provide ports: bus  input  16  register-bank output bus, valid while tr=1.
REQ-009 SHALL provide ports: in  output  16  write data to register bank.
REQ-010 SHALL provide ports: rsel  output  3  register select to register bank.
REQ-011 SHALL provide ports: wrr  output  1  register-bank write strobe.
REQ-012 SHALL provide ports: tr  output  1  register-bank bus-drive enable.
REQ-013 SHALL provide ports: busy, done, err  output  1 each; rdata  output  16  READ result.

Function
REQ-014 SHALL implement states IDLE, RD_A, RD_B, WR_A, WR_B, DONE; one register-bank phase per cycle.
REQ-015 SHALL accept a command when start=1 in IDLE, latching op/src/dst/imm; start is ignored in all other states.
REQ-016 SHALL sequence MOV: RD_A(src), WR_A(dst), DONE -- 2 bank cycles.
REQ-017 SHALL sequence SWAP: RD_A(src), RD_B(dst), WR_A(src<=data read from dst), WR_B(dst<=data read from src), DONE -- 4 bank cycles.
REQ-018 SHALL sequence LOAD: WR_A(dst<=imm), DONE; READ: RD_A(src), DONE with rdata updated.
REQ-019 In read states SHALL drive tr=1, wrr=0, rsel=index, capturing bus into a 16-bit temp at the closing clock edge.
REQ-020 In write states SHALL drive wrr=1, tr=0, rsel=index, in=data; in SHALL hold 0 outside write states.
REQ-021 SHALL never assert tr and wrr in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-022 SHALL hold busy=1 in every non-IDLE state and done=1 for exactly the single DONE cycle, then return to IDLE.
REQ-023 SHALL accept back-to-back commands: start may be high in the IDLE cycle immediately after DONE.
REQ-024 SHALL hold rdata from the last READ until the next READ completes or reset; other ops SHALL not change it.
REQ-025 SWAP with src==dst SHALL execute the full sequence, leaving the register unchanged.
REQ-026 An illegal op (see Configuration) SHALL go directly to DONE with err=1 for that cycle and no bank access.

Reset
REQ-027 reset=0 SHALL immediately force IDLE and in=0, rsel=0, wrr=0, tr=0, busy=0, done=0, err=0, rdata=0, temps=0.
REQ-028 Reset mid-command SHALL abort without completing or undoing writes already performed.
REQ-029 Operation SHALL resume on the first rising clk edge after reset returns high.

Configuration
REQ-030 Macro REGBANK_XFER_SWAP_EN defined SHALL compile in SWAP (op=01) per REQ-017, including RD_B/WR_B.
REQ-031 Without REGBANK_XFER_SWAP_EN, op=01 SHALL be illegal per REQ-026 and RD_B/WR_B and the second temp SHALL not exist.

Verification
REQ-032 LOAD dst=3 imm=0xFFFF -> one cycle wrr=1 rsel=3 in=0xFFFF, then done=1, busy=0 next cycle.
REQ-033 Bank r0=0x8000; MOV src=0 dst=2 -> cycle1 tr=1 rsel=0, cycle2 wrr=1 rsel=2 in=0x8000, cycle3 done=1.
REQ-034 r1=0x0001, r3=0xFFFF, SWAP_EN; SWAP src=1 dst=3 -> writes r1<=0xFFFF then r3<=0x0001; done after 4 bank cycles.
REQ-035 READ src=7 with bus=0x1234 during tr -> rdata=0x1234 at done; subsequent LOAD leaves rdata=0x1234.
REQ-036 Reset low during MOV read phase -> all outputs 0 immediately, no wrr pulse, next start accepted normally.
REQ-037 Without SWAP_EN, op=01 -> err=1 and done=1 one cycle after acceptance, tr=wrr=0 throughout.
